// File: rtl/ddr3_arb_pkg.sv
// ddr3_arb_pkg
//   Shared definitions for the DDR3 user-port arbiter: arbiter state
//   encoding, requester-id type, and the default bus widths that match
//   ddr3_memory_controller.
//   Optional feature macro used by the arbiter: ARB_TIMEOUT_EN.
package ddr3_arb_pkg;

    localparam int unsigned ADDRESS_BITWIDTH_DEF      = 15;
    localparam int unsigned BANK_ADDRESS_BITWIDTH_DEF = 3;
    localparam int unsigned DQ_BITWIDTH_DEF           = 16;
    localparam int unsigned REQ_ID_BITWIDTH           = 1;

    typedef logic [REQ_ID_BITWIDTH-1:0] req_id_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RD = 2'd2
    } arb_state_e;

    // Winner of a two-way round-robin: a lone requester always wins, and
    // on contention the requester that was not granted last time wins.
    function automatic req_id_t rr_pick(input logic valid_0, input logic valid_1,
                                        input req_id_t last_grant);
        req_id_t pick;
        if (valid_0 && valid_1) begin
            pick = (last_grant == req_id_t'(1)) ? req_id_t'(0) : req_id_t'(1);
        end else if (valid_1) begin
            pick = req_id_t'(1);
        end else begin
            pick = req_id_t'(0);
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2
//   Two-requester round-robin arbiter. Grants are combinational from the
//   two valids and the last granted id; the last-grant register updates
//   on an accepted command.
//   Ports:
//     clk_i, reset_i      clock, synchronous active-high reset
//     valid_0_i/valid_1_i requester n has a command
//     accept_i            the granted command is accepted on this edge
//     grant_0_o/grant_1_o requester n is the current winner
//     grant_id_o          id of the current winner
module rr_arbiter_2
    import ddr3_arb_pkg::*;
(
    input  logic    clk_i,
    input  logic    reset_i,
    input  logic    valid_0_i,
    input  logic    valid_1_i,
    input  logic    accept_i,
    output logic    grant_0_o,
    output logic    grant_1_o,
    output req_id_t grant_id_o
);

    req_id_t last_grant_q;
    req_id_t last_grant_d;
    req_id_t pick;

    always_comb begin
        pick       = rr_pick(valid_0_i, valid_1_i, last_grant_q);
        grant_0_o  = valid_0_i && (pick == req_id_t'(0));
        grant_1_o  = valid_1_i && (pick == req_id_t'(1));
        grant_id_o = pick;
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (accept_i) begin
            last_grant_d = pick;
        end
    end

    // Reset to requester 1 so that requester 0 wins the first contention.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            last_grant_q <= req_id_t'(1);
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/ddr3_user_port_arbiter.sv
// ddr3_user_port_arbiter
//   Shares the single user port of ddr3_memory_controller between two
//   requesters with round-robin fairness, one command in flight at a time.
//   Read data is routed back to the requester that issued the read.
//   Optional feature: define ARB_TIMEOUT_EN to add a watchdog that abandons
//   a command stuck in ISSUE/WAIT_RD for TIMEOUT_CYCLES cycles and pulses
//   timeout_err (parameter and port exist only with the macro).
//   Ports:
//     clk, reset                      clock, synchronous active-high reset
//     req_valid_n/req_ready_n         command handshake, requester n
//     req_write_n/req_addr_n/req_wdata_n  command contents, requester n
//     rsp_valid_n, rsp_rdata          one-cycle read-data pulse to requester n
//     write_enable/read_enable        registered command enables to controller
//     i_user_data_address/i_user_data latched command operands to controller
//     o_user_data, ctrl_rd_valid      read data from controller
//     ctrl_ready                      controller takes the enabled command
//     busy                            registered (state != IDLE)
//     timeout_err                     watchdog pulse (ARB_TIMEOUT_EN only)
module ddr3_user_port_arbiter
    import ddr3_arb_pkg::*;
#(
    parameter int unsigned ADDRESS_BITWIDTH      = ADDRESS_BITWIDTH_DEF,
    parameter int unsigned BANK_ADDRESS_BITWIDTH = BANK_ADDRESS_BITWIDTH_DEF,
    parameter int unsigned DQ_BITWIDTH           = DQ_BITWIDTH_DEF
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES        = 1023
`endif
)(
    input  logic                                             clk,
    input  logic                                             reset,
    input  logic                                             req_valid_0,
    input  logic                                             req_valid_1,
    output logic                                             req_ready_0,
    output logic                                             req_ready_1,
    input  logic                                             req_write_0,
    input  logic                                             req_write_1,
    input  logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] req_addr_0,
    input  logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] req_addr_1,
    input  logic [DQ_BITWIDTH-1:0]                           req_wdata_0,
    input  logic [DQ_BITWIDTH-1:0]                           req_wdata_1,
    output logic                                             rsp_valid_0,
    output logic                                             rsp_valid_1,
    output logic [DQ_BITWIDTH-1:0]                           rsp_rdata,
    output logic                                             write_enable,
    output logic                                             read_enable,
    output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] i_user_data_address,
    output logic [DQ_BITWIDTH-1:0]                           i_user_data,
    input  logic [DQ_BITWIDTH-1:0]                           o_user_data,
    input  logic                                             ctrl_ready,
    input  logic                                             ctrl_rd_valid,
    output logic                                             busy
`ifdef ARB_TIMEOUT_EN
    ,
    output logic                                             timeout_err
`endif
);

    localparam int unsigned AW = BANK_ADDRESS_BITWIDTH + ADDRESS_BITWIDTH;

    arb_state_e             state_q,     state_d;
    logic                   wr_q,        wr_d;
    logic [AW-1:0]          addr_q,      addr_d;
    logic [DQ_BITWIDTH-1:0] wdata_q,     wdata_d;
    req_id_t                id_q,        id_d;
    logic                   we_q,        we_d;
    logic                   re_q,        re_d;
    logic                   rsp_v0_q,    rsp_v0_d;
    logic                   rsp_v1_q,    rsp_v1_d;
    logic [DQ_BITWIDTH-1:0] rdata_q,     rdata_d;
    logic                   busy_q,      busy_d;

    logic    grant_0;
    logic    grant_1;
    req_id_t grant_id;
    logic    accept;
    logic    sel_1;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             to_q,  to_d;
    logic             expire;
`endif

    rr_arbiter_2 u_rr (
        .clk_i      (clk),
        .reset_i    (reset),
        .valid_0_i  (req_valid_0),
        .valid_1_i  (req_valid_1),
        .accept_i   (accept),
        .grant_0_o  (grant_0),
        .grant_1_o  (grant_1),
        .grant_id_o (grant_id)
    );

    always_comb begin
        req_ready_0 = (state_q == IDLE) && grant_0;
        req_ready_1 = (state_q == IDLE) && grant_1;
        // Grants already imply valid, so any ready is a completed handshake.
        accept      = req_ready_0 || req_ready_1;
        sel_1       = (grant_id == req_id_t'(1));
    end

    always_comb begin
        state_d  = state_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        id_d     = id_q;
        we_d     = 1'b0;
        re_d     = 1'b0;
        rsp_v0_d = 1'b0;
        rsp_v1_d = 1'b0;
        rdata_d  = rdata_q;
`ifdef ARB_TIMEOUT_EN
        to_d     = 1'b0;
        // Compared against the pre-increment count so the abort lands
        // exactly TIMEOUT_CYCLES cycles after ISSUE entry; >= keeps a read
        // that reached WAIT_RD late from escaping the watchdog.
        expire   = (cnt_q >= CNT_LAST);
        cnt_d    = cnt_q;
        if (state_q != IDLE && cnt_q < CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
`endif

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    wr_d    = sel_1 ? req_write_1 : req_write_0;
                    addr_d  = sel_1 ? req_addr_1  : req_addr_0;
                    wdata_d = sel_1 ? req_wdata_1 : req_wdata_0;
                    id_d    = grant_id;
                    we_d    = wr_d;
                    re_d    = !wr_d;
                    state_d = ISSUE;
`ifdef ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ISSUE: begin
                if (ctrl_ready) begin
                    state_d = wr_q ? IDLE : WAIT_RD;
`ifdef ARB_TIMEOUT_EN
                end else if (expire) begin
                    state_d = IDLE;
                    to_d    = 1'b1;
`endif
                end else begin
                    we_d = we_q;
                    re_d = re_q;
                end
            end
            WAIT_RD: begin
                if (ctrl_rd_valid) begin
                    rdata_d  = o_user_data;
                    rsp_v0_d = (id_q == req_id_t'(0));
                    rsp_v1_d = (id_q == req_id_t'(1));
                    state_d  = IDLE;
`ifdef ARB_TIMEOUT_EN
                end else if (expire) begin
                    state_d = IDLE;
                    to_d    = 1'b1;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            id_q     <= '0;
            we_q     <= 1'b0;
            re_q     <= 1'b0;
            rsp_v0_q <= 1'b0;
            rsp_v1_q <= 1'b0;
            rdata_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            id_q     <= id_d;
            we_q     <= we_d;
            re_q     <= re_d;
            rsp_v0_q <= rsp_v0_d;
            rsp_v1_q <= rsp_v1_d;
            rdata_q  <= rdata_d;
            busy_q   <= busy_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            to_q  <= to_d;
        end
    end

    assign timeout_err = to_q;
`endif

    assign write_enable        = we_q;
    assign read_enable         = re_q;
    assign i_user_data_address = addr_q;
    assign i_user_data         = wdata_q;
    assign rsp_valid_0         = rsp_v0_q;
    assign rsp_valid_1         = rsp_v1_q;
    assign rsp_rdata           = rdata_q;
    assign busy                = busy_q;

endmodule

// File: tb/tb_ddr3_user_port_arbiter.sv
// tb_ddr3_user_port_arbiter
//   Directed scenarios followed by randomized traffic, every cycle checked
//   against a transaction-level reference model (queue of in-flight
//   commands). Build with ARB_TIMEOUT_EN to include the watchdog scenario.
module tb_ddr3_user_port_arbiter;

    localparam int AW = 18;
    localparam int DW = 16;
    localparam int TO = 8;

    logic          clk;
    logic          reset;
    logic          req_valid_0, req_valid_1;
    logic          req_ready_0, req_ready_1;
    logic          req_write_0, req_write_1;
    logic [AW-1:0] req_addr_0, req_addr_1;
    logic [DW-1:0] req_wdata_0, req_wdata_1;
    logic          rsp_valid_0, rsp_valid_1;
    logic [DW-1:0] rsp_rdata;
    logic          write_enable, read_enable;
    logic [AW-1:0] i_user_data_address;
    logic [DW-1:0] i_user_data;
    logic [DW-1:0] o_user_data;
    logic          ctrl_ready, ctrl_rd_valid;
    logic          busy;
`ifdef ARB_TIMEOUT_EN
    logic          timeout_err;
`endif

    ddr3_user_port_arbiter #(
        .ADDRESS_BITWIDTH      (15),
        .BANK_ADDRESS_BITWIDTH (3),
        .DQ_BITWIDTH           (16)
`ifdef ARB_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES        (TO)
`endif
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .req_valid_0         (req_valid_0),
        .req_valid_1         (req_valid_1),
        .req_ready_0         (req_ready_0),
        .req_ready_1         (req_ready_1),
        .req_write_0         (req_write_0),
        .req_write_1         (req_write_1),
        .req_addr_0          (req_addr_0),
        .req_addr_1          (req_addr_1),
        .req_wdata_0         (req_wdata_0),
        .req_wdata_1         (req_wdata_1),
        .rsp_valid_0         (rsp_valid_0),
        .rsp_valid_1         (rsp_valid_1),
        .rsp_rdata           (rsp_rdata),
        .write_enable        (write_enable),
        .read_enable         (read_enable),
        .i_user_data_address (i_user_data_address),
        .i_user_data         (i_user_data),
        .o_user_data         (o_user_data),
        .ctrl_ready          (ctrl_ready),
        .ctrl_rd_valid       (ctrl_rd_valid),
        .busy                (busy)
`ifdef ARB_TIMEOUT_EN
        ,
        .timeout_err         (timeout_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: at most one in-flight command; stage 0 = offered to
    // the controller, stage 1 = waiting for read data.
    typedef struct {
        bit            id;
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            stage;
        int            age;
    } txn_t;

    txn_t          inflight[$];
    bit            m_last;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    bit            m_rsp0, m_rsp1, m_to;

    // What the DUT showed on the most recent checked cycle.
    logic seen_r0, seen_r1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit winner_is_1();
        if (req_valid_0 && req_valid_1) return !m_last;
        return req_valid_1;
    endfunction

    function automatic bit exp_grant(input bit n);
        if (!(n ? req_valid_1 : req_valid_0)) return 1'b0;
        return winner_is_1() == n;
    endfunction

    task automatic model_reset();
        inflight.delete();
        m_last  = 1'b1;
        m_addr  = '0;
        m_wdata = '0;
        m_rdata = '0;
        m_rsp0  = 1'b0;
        m_rsp1  = 1'b0;
        m_to    = 1'b0;
    endtask

    task automatic model_edge();
        txn_t t;
        bit   done;
        bit   advanced;
        bit   idle;
        bit   g0, g1;
        idle = (inflight.size() == 0);
        g0   = idle && exp_grant(1'b0);
        g1   = idle && exp_grant(1'b1);
        m_rsp0 = 1'b0;
        m_rsp1 = 1'b0;
        m_to   = 1'b0;
        if (reset) begin
            model_reset();
        end else if (idle) begin
            if (g0 || g1) begin
                t.id    = g1;
                t.wr    = g1 ? req_write_1 : req_write_0;
                t.addr  = g1 ? req_addr_1  : req_addr_0;
                t.data  = g1 ? req_wdata_1 : req_wdata_0;
                t.stage = 0;
                t.age   = 0;
                inflight.push_back(t);
                m_last  = g1;
                m_addr  = t.addr;
                m_wdata = t.data;
            end
        end else begin
            t = inflight[0];
            done = 1'b0;
            advanced = 1'b0;
            if (t.stage == 0 && ctrl_ready) begin
                if (t.wr) done = 1'b1;
                else begin
                    t.stage  = 1;
                    advanced = 1'b1;
                end
            end else if (t.stage == 1 && ctrl_rd_valid) begin
                m_rdata = o_user_data;
                if (t.id) m_rsp1 = 1'b1;
                else      m_rsp0 = 1'b1;
                done = 1'b1;
            end
            if (done) begin
                void'(inflight.pop_front());
            end else begin
`ifdef ARB_TIMEOUT_EN
                if (t.age < TO) t.age++;
                if (!advanced && t.age >= TO) begin
                    m_to = 1'b1;
                    void'(inflight.pop_front());
                end else begin
                    inflight[0] = t;
                end
`else
                inflight[0] = t;
`endif
            end
        end
    endtask

    // One clock: check all outputs mid-cycle, then advance the model on the edge.
    task automatic cycle();
        bit idle;
        bit offer;
        bit wr;
        @(negedge clk);
        idle  = (inflight.size() == 0);
        offer = !idle && inflight[0].stage == 0;
        wr    = !idle && inflight[0].wr;
        seen_r0 = req_ready_0;
        seen_r1 = req_ready_1;
        chk("ready0", req_ready_0, idle && exp_grant(1'b0));
        chk("ready1", req_ready_1, idle && exp_grant(1'b1));
        chk("we",     write_enable, offer && wr);
        chk("re",     read_enable,  offer && !wr);
        chk("addr",   i_user_data_address, m_addr);
        chk("wdata",  i_user_data, m_wdata);
        chk("rsp0",   rsp_valid_0, m_rsp0);
        chk("rsp1",   rsp_valid_1, m_rsp1);
        chk("rdata",  rsp_rdata, m_rdata);
        chk("busy",   busy, !idle);
`ifdef ARB_TIMEOUT_EN
        chk("timeout", timeout_err, m_to);
`endif
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic quiet_inputs();
        req_valid_0   = 1'b0;
        req_valid_1   = 1'b0;
        req_write_0   = 1'b0;
        req_write_1   = 1'b0;
        req_addr_0    = '0;
        req_addr_1    = '0;
        req_wdata_0   = '0;
        req_wdata_1   = '0;
        o_user_data   = '0;
        ctrl_ready    = 1'b0;
        ctrl_rd_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        int got[4];
        int n;
        int waited;

        model_reset();
        quiet_inputs();
        reset = 1'b1;
        #1;
        do_reset();

        // Reset state.
        chk("rst_busy", busy, 1'b0);
        chk("rst_we",   write_enable, 1'b0);
        chk("rst_rsp",  {rsp_valid_1, rsp_valid_0}, 2'b00);

        // 1: write handshake with ctrl_ready tied high.
        ctrl_ready  = 1'b1;
        req_valid_0 = 1'b1;
        req_write_0 = 1'b1;
        req_addr_0  = 18'h12345;
        req_wdata_0 = 16'hBEEF;
        cycle();
        chk("t1_ready0", seen_r0, 1'b1);
        req_valid_0 = 1'b0;
        chk("t1_we",   write_enable, 1'b1);
        chk("t1_addr", i_user_data_address, 18'h12345);
        chk("t1_data", i_user_data, 16'hBEEF);
        cycle();
        chk("t1_busy", busy, 1'b0);
        cycle();

        // 2: simultaneous requests alternate 0,1,0,1.
        do_reset();
        ctrl_ready  = 1'b1;
        req_valid_0 = 1'b1;
        req_valid_1 = 1'b1;
        req_write_0 = 1'b1;
        req_write_1 = 1'b1;
        n = 0;
        waited = 0;
        while (n < 4 && waited < 40) begin
            cycle();
            waited++;
            if (seen_r0 || seen_r1) begin
                chk("t2_one_ready", {31'd0, seen_r0 && seen_r1}, 32'd0);
                got[n] = seen_r1 ? 1 : 0;
                n++;
                req_wdata_0 = DW'($urandom);
                req_wdata_1 = DW'($urandom);
            end
        end
        chk("t2_count", n, 4);
        chk("t2_order", {got[0][0], got[1][0], got[2][0], got[3][0]}, 4'b0101);
        quiet_inputs();
        cycle();
        cycle();

        // 3: read routed back to requester 1.
        do_reset();
        ctrl_ready  = 1'b1;
        req_valid_1 = 1'b1;
        req_write_1 = 1'b0;
        req_addr_1  = 18'h00007;
        cycle();
        req_valid_1 = 1'b0;
        chk("t3_re", read_enable, 1'b1);
        for (int i = 0; i < 5; i++) cycle();
        ctrl_rd_valid = 1'b1;
        o_user_data   = 16'hA5A5;
        cycle();
        ctrl_rd_valid = 1'b0;
        chk("t3_rsp1",  rsp_valid_1, 1'b1);
        chk("t3_rsp0",  rsp_valid_0, 1'b0);
        chk("t3_rdata", rsp_rdata, 16'hA5A5);
        cycle();
        chk("t3_rsp1_off", rsp_valid_1, 1'b0);

        // 4: backpressure holds enable and operands; no new ready.
        do_reset();
        ctrl_ready  = 1'b0;
        req_valid_0 = 1'b1;
        req_write_0 = 1'b1;
        req_addr_0  = 18'h3ABCD;
        req_wdata_0 = 16'h1234;
        req_valid_1 = 1'b1;
        req_write_1 = 1'b1;
        req_addr_1  = 18'h00F0F;
        cycle();
        req_valid_0 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("t4_we",     write_enable, 1'b1);
            chk("t4_addr",   i_user_data_address, 18'h3ABCD);
            chk("t4_ready1", seen_r1, 1'b0);
        end
        ctrl_ready = 1'b1;
        waited = 0;
        while (req_valid_1 && waited < 10) begin
            cycle();
            waited++;
            if (seen_r1) req_valid_1 = 1'b0;
        end
        chk("t4_drain", req_valid_1, 1'b0);
        cycle();
        cycle();

        // 5: reset while waiting for read data.
        do_reset();
        ctrl_ready  = 1'b1;
        req_valid_0 = 1'b1;
        req_write_0 = 1'b0;
        req_addr_0  = 18'h00055;
        cycle();
        req_valid_0 = 1'b0;
        cycle();
        cycle();
        chk("t5_busy_pre", busy, 1'b1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("t5_busy", busy, 1'b0);
        chk("t5_en",   {write_enable, read_enable}, 2'b00);
        chk("t5_rsp",  {rsp_valid_1, rsp_valid_0}, 2'b00);
        chk("t5_addr", i_user_data_address, 18'h0);
        ctrl_rd_valid = 1'b1;
        o_user_data   = 16'h1111;
        cycle();
        ctrl_rd_valid = 1'b0;
        chk("t5_no_rsp", {rsp_valid_1, rsp_valid_0}, 2'b00);
        cycle();

`ifdef ARB_TIMEOUT_EN
        // 6: watchdog fires TO cycles after ISSUE entry.
        do_reset();
        ctrl_ready  = 1'b0;
        req_valid_0 = 1'b1;
        req_write_0 = 1'b1;
        cycle();
        req_valid_0 = 1'b0;
        waited = 0;
        while (timeout_err !== 1'b1 && waited < 30) begin
            cycle();
            waited++;
        end
        chk("t6_latency", waited, TO);
        chk("t6_busy",    busy, 1'b0);
        cycle();
        chk("t6_pulse",   timeout_err, 1'b0);
`endif

        // Randomized traffic against the model.
        do_reset();
        quiet_inputs();
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) == 0);
            if (!req_valid_0 && $urandom_range(0, 2) == 0) begin
                req_valid_0 = 1'b1;
                req_write_0 = 1'($urandom);
                req_addr_0  = AW'($urandom);
                req_wdata_0 = DW'($urandom);
            end
            if (!req_valid_1 && $urandom_range(0, 2) == 0) begin
                req_valid_1 = 1'b1;
                req_write_1 = 1'($urandom);
                req_addr_1  = AW'($urandom);
                req_wdata_1 = DW'($urandom);
            end
            ctrl_ready    = ($urandom_range(0, 2) == 0);
            ctrl_rd_valid = ($urandom_range(0, 3) == 0);
            o_user_data   = DW'($urandom);
            cycle();
            if (seen_r0 && !reset) req_valid_0 = 1'b0;
            if (seen_r1 && !reset) req_valid_1 = 1'b0;
        end
        reset = 1'b0;
        quiet_inputs();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ddr3_user_port_arbiter.md
Name: ddr3_user_port_arbiter

Overview:
Shares the single user port of ddr3_memory_controller between two requesters, for example a loopback tester and a DMA engine.
- Accepts one command at a time from either requester, with round-robin fairness.
- Drives the controller's write_enable/read_enable, address and data lines.
- Routes each read result back to the requester that issued the read.
- Sits between the user logic and ddr3_memory_controller in the top-level.

Parameters:
- ADDRESS_BITWIDTH, 15, DDR3 row/column address width (2GB part).
- BANK_ADDRESS_BITWIDTH, 3, bank address width (8 banks).
- DQ_BITWIDTH, 16, user data width (x16 part).
- TIMEOUT_CYCLES, 1023, watchdog limit; used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  host clock
- reset  in  1  synchronous, active-high reset
- req_valid_0 / req_valid_1  in  1  requester n has a command
- req_ready_0 / req_ready_1  out  1  command from requester n accepted this cycle
- req_write_0 / req_write_1  in  1  1 = write, 0 = read
- req_addr_0 / req_addr_1  in  BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH  target address
- req_wdata_0 / req_wdata_1  in  DQ_BITWIDTH  write data
- rsp_valid_0 / rsp_valid_1  out  1  one-cycle read-data pulse to requester n
- rsp_rdata  out  DQ_BITWIDTH  read data, valid with rsp_valid_n
- write_enable  out  1  to controller
- read_enable  out  1  to controller
- i_user_data_address  out  BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH  to controller
- i_user_data  out  DQ_BITWIDTH  to controller
- o_user_data  in  DQ_BITWIDTH  read data from controller
- ctrl_ready  in  1  controller accepts the enabled command on this edge
- ctrl_rd_valid  in  1  o_user_data holds read data this cycle
- busy  out  1  state != IDLE
- timeout_err  out  1  present only with ARB_TIMEOUT_EN

Behaviour:
- Single clock domain. Reset is synchronous and active-high; clock port is clk, reset port is reset.
- Reset values:
  - All outputs 0; rsp_rdata 0.
  - State IDLE; last_grant = 1, so requester 0 wins first.
- States: IDLE, ISSUE, WAIT_RD.
- IDLE arbitration:
  - req_ready_n is combinational: (state==IDLE) && grant_n.
  - One valid requester: it is granted.
  - Both valid: the requester != last_grant is granted.
  - Handshake completes on an edge where valid_n && ready_n. On that edge: latch write/addr/wdata and the grant id, set last_grant = id, go to ISSUE.
- ISSUE:
  - Registered write_enable or read_enable is high, together with the latched address/data, starting the cycle after acceptance.
  - Enable and operands are held stable until an edge with ctrl_ready=1.
  - On that edge the enable drops. A write returns to IDLE; a read goes to WAIT_RD.
- WAIT_RD:
  - On ctrl_rd_valid=1, register o_user_data into rsp_rdata and pulse rsp_valid_<id> for exactly one cycle, then go to IDLE.
- Throughput: at most one command in flight. Minimum write turnaround is 2 cycles (accept, issue with ctrl_ready=1).
- req_ready is never asserted outside IDLE. A requester holding valid keeps its data stable until ready.
- ctrl_rd_valid outside WAIT_RD is ignored.
- ctrl_ready while no enable is asserted is ignored.
- Reset mid-operation: the in-flight command is abandoned, no rsp pulse is produced, and enables drop the next cycle.
- Address and data pass through unchanged; no width arithmetic.
- busy is registered and equals (state != IDLE).

Optional Feature:
Macro ARB_TIMEOUT_EN.
- With it:
  - A counter clears on entry to ISSUE and counts in ISSUE and WAIT_RD.
  - When it reaches TIMEOUT_CYCLES: drop the enables, pulse timeout_err for 1 cycle, go to IDLE.
  - An abandoned read produces no rsp pulse.
  - The counter saturates and never wraps.
- Without it: the timeout_err port and the counter are absent, and the block waits indefinitely.

Decomposition:
- Package ddr3_arb_pkg: state encoding constants (IDLE=0, ISSUE=1, WAIT_RD=2), requester-id width, and the default width constants shared with ddr3_memory_controller.
- Sub-module rr_arbiter_2: combinational grant from two valids plus last_grant, with a registered last_grant update on accept.

Test Plan:
1. Write handshake: after reset, req_valid_0=1, write, addr=0x12345, wdata=0xBEEF, ctrl_ready tied 1 → req_ready_0 in cycle 0; write_enable=1 with address 0x12345 and data 0xBEEF in cycle 1; busy=0 in cycle 2.
2. Simultaneous requests: both valid from reset → grants alternate 0,1,0,1 over 4 commands; the non-granted ready stays 0.
3. Read routing: requester 1 reads 0x00007; ctrl_rd_valid is asserted 5 cycles later with o_user_data=0xA5A5 → rsp_valid_1 pulses once with rsp_rdata=0xA5A5; rsp_valid_0 stays 0.
4. Backpressure: ctrl_ready held 0 for 10 cycles → write_enable and address stable for all 10 cycles; no new req_ready while held.
5. Reset mid-read: reset asserted in WAIT_RD → next cycle all outputs 0; a later ctrl_rd_valid produces no rsp.
6. ARB_TIMEOUT_EN with TIMEOUT_CYCLES=8: ctrl_ready never rises → timeout_err pulses once 8 cycles after ISSUE entry; state returns to IDLE.
